seq_chk_mon: RTL

- Synthesizable, run-time-programmable multi-step sequence checker. It is the hardware counterpart of a clocked concurrent assertion of the form `s0 ##d1 s1 ##d2 s2 ...`.
- Each step tests one selectable bit of a monitored bus, after a programmable cycle delay from the previous step.
- Overlapping attempts are tracked concurrently. Every attempt reports pass or fail with the start-cycle stamp of the offending attempt, plus the failing step. Saturating statistics counters are included.
- Sits beside the DUT in simulation and FPGA debug builds, as a replacement for non-synthesizable property checks.

---
 rtl/seq_chk_mon_if.sv | 41 ++++
 rtl/seq_chk_mon.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_chk_mon_if.sv
// Bundle of monitored bus, run-time step config and verdict outputs for seq_chk_mon.
// The master side drives the bus/config; the checker sits on the slave side.
interface seq_chk_mon_if #(
    parameter int N_SIG   = 4,
    parameter int N_STEPS = 4,
    parameter int MAX_DLY = 3,
    parameter int CW      = 16
);
    localparam int SW  = (N_SIG > 1) ? $clog2(N_SIG) : 1;
    localparam int SPW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int DW  = $clog2(MAX_DLY + 1);

    logic                  en;
    logic                  mode;
    logic                  cfg_wr;
    logic [N_STEPS*SW-1:0] cfg_sel;
    logic [N_STEPS*DW-1:0] cfg_dly;
    logic [N_SIG-1:0]      sig;

    logic                  pass;
    logic [CW-1:0]         pass_start;
    logic                  fail;
    logic [CW-1:0]         fail_start;
    logic [SPW-1:0]        fail_step;
    logic                  fail_multi;
    logic [CW-1:0]         pass_cnt;
    logic [CW-1:0]         fail_cnt;
    logic                  busy;

    modport master (
        output en, mode, cfg_wr, cfg_sel, cfg_dly, sig,
        input  pass, pass_start, fail, fail_start, fail_step, fail_multi,
               pass_cnt, fail_cnt, busy
    );

    modport slave (
        input  en, mode, cfg_wr, cfg_sel, cfg_dly, sig,
        output pass, pass_start, fail, fail_start, fail_step, fail_multi,
               pass_cnt, fail_cnt, busy
    );
endinterface

// File: rtl/seq_chk_mon.sv
// Programmable multi-step sequence checker: an age pipeline of in-flight attempts,
// each checked against one selected bus bit at the cumulative offset of every step.
module seq_chk_mon #(
    parameter int N_SIG   = 4,
    parameter int N_STEPS = 4,
    parameter int MAX_DLY = 3,
    parameter int CW      = 16
) (
    input  logic         clk,
    input  logic         rst,
    seq_chk_mon_if.slave mon
);
    localparam int SW    = (N_SIG > 1) ? $clog2(N_SIG) : 1;
    localparam int SPW   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int DW    = $clog2(MAX_DLY + 1);
    localparam int DEPTH = N_STEPS * MAX_DLY + 1;

    logic [SW-1:0]    sel_q [N_STEPS];
    logic [SW-1:0]    sel_d [N_STEPS];
    logic [DW-1:0]    dly_q [N_STEPS];
    logic [DW-1:0]    dly_d [N_STEPS];
    logic [CW-1:0]    stamp_q, stamp_d;
    // vld_q[i] / slot_st_q[i]: attempt that will be age i+1 at the next edge
    logic [DEPTH-2:0] vld_q, vld_d;
    logic [CW-1:0]    slot_st_q [DEPTH-1];
    logic [CW-1:0]    slot_st_d [DEPTH-1];

    logic             pass_q, pass_d;
    logic [CW-1:0]    pass_start_q, pass_start_d;
    logic             fail_q, fail_d;
    logic [CW-1:0]    fail_start_q, fail_start_d;
    logic [SPW-1:0]   fail_step_q, fail_step_d;
    logic             fail_multi_q, fail_multi_d;
    logic [CW-1:0]    pass_cnt_q, pass_cnt_d;
    logic [CW-1:0]    fail_cnt_q, fail_cnt_d;
    logic             busy_q, busy_d;

    logic [2**SW-1:0] sig_ext;
    logic [N_STEPS-1:0] step_bit;
    int               offs [N_STEPS];
    int               dly_acc;
    logic [DEPTH-1:0] cand_v;
    logic [CW-1:0]    cand_st [DEPTH];
    logic [DEPTH-1:0] cand_fail;
    logic [SPW-1:0]   cand_step [DEPTH];
    int               n_pass, n_fail;
    logic [CW:0]      pass_sum, fail_sum;

    // Zero-padding the bus makes an out-of-range select read as 0.
    always_comb begin
        sig_ext = '0;
        sig_ext[N_SIG-1:0] = mon.sig;
        for (int k = 0; k < N_STEPS; k++) begin
            step_bit[k] = sig_ext[sel_q[k]];
        end
    end

    always_comb begin
        dly_acc = 0;
        offs[0] = 0;
        for (int k = 1; k < N_STEPS; k++) begin
            dly_acc = dly_acc + int'(dly_q[k]);
            offs[k] = dly_acc;
        end
    end

    // Age 0 is the would-be new attempt; triggered mode drops it on a step-0 miss.
    always_comb begin
        cand_v[0]  = mon.en && !(mon.mode && !step_bit[0]);
        cand_st[0] = stamp_q;
        for (int a = 1; a < DEPTH; a++) begin
            cand_v[a]  = vld_q[a-1];
            cand_st[a] = slot_st_q[a-1];
        end
        for (int a = 0; a < DEPTH; a++) begin
            cand_fail[a] = 1'b0;
            cand_step[a] = '0;
            for (int k = N_STEPS - 1; k >= 0; k--) begin
                if (offs[k] == a && !step_bit[k]) begin
                    cand_fail[a] = 1'b1;
                    cand_step[a] = SPW'(k);
                end
            end
        end
    end

    always_comb begin
        sel_d        = sel_q;
        dly_d        = dly_q;
        stamp_d      = stamp_q + CW'(1);
        vld_d        = '0;
        slot_st_d    = slot_st_q;
        pass_d       = 1'b0;
        pass_start_d = pass_start_q;
        fail_d       = 1'b0;
        fail_start_d = fail_start_q;
        fail_step_d  = fail_step_q;
        fail_multi_d = 1'b0;
        n_pass       = 0;
        n_fail       = 0;
        if (mon.cfg_wr) begin
            for (int k = 0; k < N_STEPS; k++) begin
                sel_d[k] = mon.cfg_sel[k*SW +: SW];
                dly_d[k] = mon.cfg_dly[k*DW +: DW];
            end
        end else begin
            // Ascending age: the last hit written is the oldest attempt.
            for (int a = 0; a < DEPTH; a++) begin
                if (cand_v[a] && cand_fail[a]) begin
                    n_fail       = n_fail + 1;
                    fail_d       = 1'b1;
                    fail_start_d = cand_st[a];
                    fail_step_d  = cand_step[a];
                end else if (cand_v[a] && a == offs[N_STEPS-1]) begin
                    n_pass       = n_pass + 1;
                    pass_d       = 1'b1;
                    pass_start_d = cand_st[a];
                end
            end
            for (int a = 0; a < DEPTH - 1; a++) begin
                if (cand_v[a] && !cand_fail[a] && a < offs[N_STEPS-1]) begin
                    vld_d[a]     = 1'b1;
                    slot_st_d[a] = cand_st[a];
                end
            end
            fail_multi_d = (n_fail > 1);
        end
        pass_sum   = {1'b0, pass_cnt_q} + (CW+1)'(n_pass);
        fail_sum   = {1'b0, fail_cnt_q} + (CW+1)'(n_fail);
        pass_cnt_d = pass_sum[CW] ? '1 : pass_sum[CW-1:0];
        fail_cnt_d = fail_sum[CW] ? '1 : fail_sum[CW-1:0];
        busy_d     = |vld_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_STEPS; k++) begin
                sel_q[k] <= '0;
                dly_q[k] <= DW'(1);
            end
            for (int i = 0; i < DEPTH - 1; i++) begin
                slot_st_q[i] <= '0;
            end
            stamp_q      <= '0;
            vld_q        <= '0;
            pass_q       <= 1'b0;
            pass_start_q <= '0;
            fail_q       <= 1'b0;
            fail_start_q <= '0;
            fail_step_q  <= '0;
            fail_multi_q <= 1'b0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            dly_q        <= dly_d;
            slot_st_q    <= slot_st_d;
            stamp_q      <= stamp_d;
            vld_q        <= vld_d;
            pass_q       <= pass_d;
            pass_start_q <= pass_start_d;
            fail_q       <= fail_d;
            fail_start_q <= fail_start_d;
            fail_step_q  <= fail_step_d;
            fail_multi_q <= fail_multi_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign mon.pass       = pass_q;
    assign mon.pass_start = pass_start_q;
    assign mon.fail       = fail_q;
    assign mon.fail_start = fail_start_q;
    assign mon.fail_step  = fail_step_q;
    assign mon.fail_multi = fail_multi_q;
    assign mon.pass_cnt   = pass_cnt_q;
    assign mon.fail_cnt   = fail_cnt_q;
    assign mon.busy       = busy_q;
endmodule
